// File: rtl/opll_write_queue.sv
// opll_write_queue: queues FM-PAC mapped and I/O OPLL writes and replays them to
// the two OPLL cores with YM2413 address/data settle waits between strobes.
module opll_write_queue #(
    parameter int DEPTH     = 8,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_opll,
    input  logic [15:0] addr,
    input  logic [7:0]  d_from_cpu,
    input  logic        wr,
    input  logic        iorq,
    input  logic [1:0]  opll_wr,
    input  logic [1:0]  opll_io_enable,
    output logic [1:0]  opll_we,
    output logic        opll_a0,
    output logic [7:0]  opll_d,
    output logic        busy,
    output logic        overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [10:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [CNTW-1:0]   r_count;
    logic              r_io_hit, r_ovf, r_a0;
    logic [1:0]        r_mask;
    logic [7:0]        r_d;
    logic              w_io_hit, w_io_stb, w_push, w_full, w_do_push, w_pop;
    logic [1:0]        w_mask, w_we;
    logic [10:0]       w_head;

    assign w_io_hit  = iorq & wr & (addr[7:1] == 7'b0111110);
    assign w_io_stb  = w_io_hit & ~r_io_hit;
    assign w_mask    = opll_wr | ({2{w_io_stb}} & opll_io_enable);
    assign w_push    = |w_mask;
    assign w_full    = r_count == CNTW'(DEPTH);
    // A pop frees a slot in the same edge, so a full FIFO still accepts the push.
    assign w_do_push = w_push & (~w_full | w_pop);
    assign w_head    = r_mem[r_rp];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_we        = 2'b00;
        case (r_state)
            S_IDLE: begin
                w_pop       = r_count != '0;
                w_state_nxt = w_pop ? S_DRIVE : S_IDLE;
            end
            S_DRIVE: begin
                w_we        = r_mask;
                w_cnt_nxt   = r_a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = (r_cnt == '0) ? S_IDLE : S_WAIT;
                w_cnt_nxt   = (r_cnt != '0 && ce_opll) ? r_cnt - CW'(1) : r_cnt;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp] <= {w_mask, addr[0], d_from_cpu};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_io_hit <= 1'b0;
            r_ovf    <= 1'b0;
            r_mask   <= 2'b00;
            r_a0     <= 1'b0;
            r_d      <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_io_hit <= w_io_hit;
            r_count  <= r_count + CNTW'(w_do_push) - CNTW'(w_pop);
            if (w_do_push) r_wp <= r_wp + AW'(1);
            if (w_pop) begin
                r_rp   <= r_rp + AW'(1);
                r_mask <= w_head[10:9];
                r_a0   <= w_head[8];
                r_d    <= w_head[7:0];
            end
            if (w_push && !w_do_push) r_ovf <= 1'b1;
        end
    end

    assign opll_we  = w_we;
    assign opll_a0  = r_a0;
    assign opll_d   = r_d;
    assign busy     = (r_count != '0) | (r_state != S_IDLE);
    assign overflow = r_ovf;
endmodule
